// File: rtl/left_shifter_seq.sv
// Iterative left shifter: applies one log-shift stage (1, 2, 4, 8, 16) per clock.
// Supports logical shift-left and rotate-left, with a carry-out and a start/done handshake.
module left_shifter_seq #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  in,
  input  logic [STAGES-1:0] sha,
  input  logic              op,
  output logic [WIDTH-1:0]  out,
  output logic              carry,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(STAGES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state_reg;
  logic [CW-1:0]     stage_reg;
  logic [WIDTH-1:0]  w_reg;
  logic              c_reg;
  logic [STAGES-1:0] sha_reg;
  logic              op_reg;
  logic [WIDTH-1:0]  out_reg;
  logic              carry_reg;

  logic [WIDTH-1:0]  shl_cand [STAGES];
  logic [WIDTH-1:0]  rol_cand [STAGES];
  logic [STAGES-1:0] cbit_cand;
  logic [STAGES-1:0] stage_hit;

  logic [WIDTH-1:0]  w_next;
  logic              c_next;
  logic              last_stage;

  // Each stage precomputes both shift flavours of the work register; only the
  // stage matching the counter (and enabled by its sha bit) is selected below.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int D = 1 << gi;
      assign shl_cand[gi]  = {w_reg[WIDTH-1-D:0], {D{1'b0}}};
      assign rol_cand[gi]  = {w_reg[WIDTH-1-D:0], w_reg[WIDTH-1:WIDTH-D]};
      assign cbit_cand[gi] = w_reg[WIDTH-D];
      assign stage_hit[gi] = (stage_reg == CW'(gi)) && sha_reg[gi];
    end
  endgenerate

  // The bit leaving position WIDTH-D is also what a rotate wraps into bit 0,
  // so the same carry capture serves both modes.
  always_comb begin
    w_next = w_reg;
    c_next = c_reg;
    for (int i = 0; i < STAGES; i++) begin
      if (stage_hit[i]) begin
        w_next = op_reg ? rol_cand[i] : shl_cand[i];
        c_next = cbit_cand[i];
      end
    end
  end

  assign last_stage = (stage_reg == CW'(STAGES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      stage_reg <= '0;
      w_reg     <= '0;
      c_reg     <= 1'b0;
      sha_reg   <= '0;
      op_reg    <= 1'b0;
      out_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            w_reg     <= in;
            sha_reg   <= sha;
            op_reg    <= op;
            c_reg     <= 1'b0;
            stage_reg <= '0;
            state_reg <= SHIFT;
          end else begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          w_reg <= w_next;
          c_reg <= c_next;
          if (last_stage) begin
            out_reg   <= w_next;
            carry_reg <= c_next;
            stage_reg <= '0;
            state_reg <= DONE;
          end else begin
            stage_reg <= stage_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          stage_reg <= '0;
        end
      endcase
    end
  end

  assign out   = out_reg;
  assign carry = carry_reg;
  assign busy  = (state_reg == SHIFT);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_left_shifter_seq.sv
// Self-checking bench for left_shifter_seq: directed cases from the test plan plus
// randomized traffic, all compared every cycle against a cycle-count reference model.
module tb_left_shifter_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in = '0;
  logic [4:0]  sha = '0;
  logic        op = 1'b0;
  logic [31:0] out;
  logic        carry;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  // reference model state
  int          m_cnt = 0;
  logic [31:0] m_out = '0;
  logic        m_carry = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] p_out = '0;
  logic        p_carry = 1'b0;

  left_shifter_seq dut (
    .clk(clk), .reset(reset), .start(start), .in(in), .sha(sha), .op(op),
    .out(out), .carry(carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_out(logic [31:0] a, int s, logic rot);
    if (s == 0) return a;
    if (rot) return (a << s) | (a >> (32 - s));
    return a << s;
  endfunction

  function automatic logic f_carry(logic [31:0] a, int s, logic rot);
    logic [31:0] r;
    if (s == 0) return 1'b0;
    if (rot) begin
      r = f_out(a, s, 1'b1);
      return r[0];
    end
    return a[32 - s];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request produces its result 5 edges later.
  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0; m_out <= '0; m_carry <= 1'b0; m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) begin
        m_out   <= p_out;
        m_carry <= p_carry;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        p_out   <= f_out(in, int'(sha), op);
        p_carry <= f_carry(in, int'(sha), op);
        m_cnt   <= 5;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  32'(busy),  32'(m_cnt != 0));
      chk("done",  32'(done),  32'(m_done));
      chk("out",   out,        m_out);
      chk("carry", 32'(carry), 32'(m_carry));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for done with a bound, and check latency and literal result.
  task automatic do_op(logic [31:0] a, logic [4:0] s, logic o,
                       logic [31:0] exp_out, logic exp_carry, string name);
    int lat;
    start = 1'b1; in = a; sha = s; op = o;
    tick();
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'd5);
    chk({name, "_out"}, out, exp_out);
    chk({name, "_carry"}, 32'(carry), 32'(exp_carry));
    $display("op %s in=0x%08h sha=%0d op=%0d -> out=0x%08h carry=%0d lat=%0d",
             name, a, s, o, out, carry, lat);
  endtask

  initial begin
    int seen;
    tick(); tick();
    chk_en = 1'b1;
    chk("reset_out", out, 32'h0);
    reset = 1'b0;
    tick();

    do_op(32'h00000001, 5'd31, 1'b0, 32'h80000000, 1'b0, "t1");
    tick();
    do_op(32'h80000001, 5'd1,  1'b0, 32'h00000002, 1'b1, "t2a");
    do_op(32'hF0000000, 5'd4,  1'b0, 32'h00000000, 1'b1, "t2b");
    do_op(32'h80000001, 5'd4,  1'b1, 32'h00000018, 1'b0, "t3a");
    do_op(32'h12345678, 5'd16, 1'b1, 32'h56781234, 1'b0, "t3b");
    do_op(32'hDEADBEEF, 5'd0,  1'b0, 32'hDEADBEEF, 1'b0, "t4a");
    do_op(32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF, 1'b0, "t4b");

    // ignored start during busy, then back-to-back accept in the done cycle
    start = 1'b1; in = 32'h1; sha = 5'd2; op = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; in = 32'hFFFFFFFF; sha = 5'd7; op = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin seen = 1; break; end
      tick();
    end
    chk("t5_done_seen", 32'(seen), 32'd1);
    chk("t5a_out", out, 32'h00000004);
    $display("op t5a out=0x%08h", out);
    start = 1'b1; in = 32'h3; sha = 5'd3; op = 1'b0;
    tick();
    start = 1'b0;
    chk("t5_busy_b2b", 32'(busy), 32'd1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) begin seen = 1; break; end
    end
    chk("t5_done2_seen", 32'(seen), 32'd1);
    chk("t5b_out", out, 32'h00000018);
    $display("op t5b out=0x%08h", out);
    tick();

    // reset mid-shift aborts without a done pulse
    start = 1'b1; in = 32'h1; sha = 5'd31; op = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_out", out, 32'h0);
    chk("t6_carry", 32'(carry), 32'd0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) seen = 1;
    end
    chk("t6_no_done", 32'(seen), 32'd0);
    $display("op t6 reset abort done_seen=%0d", seen);

    // reset and start together: reset wins
    reset = 1'b1; start = 1'b1; in = 32'h5; sha = 5'd1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("t7_busy", 32'(busy), 32'd0);

    // randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 2) == 0);
      in    = $urandom;
      case ($urandom_range(0, 5))
        0:       sha = 5'd0;
        1:       sha = 5'd31;
        default: sha = 5'($urandom);
      endcase
      op    = 1'($urandom);
      reset = ($urandom_range(0, 80) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0;
    tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
